// File: rtl/vend_pkg.sv
// Shared types and codes for the vending purchase controller.
package vend_pkg;

  // Purchase sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_VEND  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  // Error codes reported on err_code while error is high
  localparam logic [1:0] ERR_INSUFF   = 2'd0;
  localparam logic [1:0] ERR_SOLD_OUT = 2'd1;
  localparam logic [1:0] ERR_BAD_BCD  = 2'd2;
  localparam logic [1:0] ERR_BAD_SEL  = 2'd3;

  // Width of each per-product stock counter
  localparam int STOCK_W = 4;

endpackage

// File: rtl/bcd_sub.sv
// Digit-wise BCD subtractor: diff = a - b with a borrow ripple across nibbles.
// A final borrow means a < b. invalid flags any non-decimal nibble in either operand.
module bcd_sub #(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] a_bcd,
  input  logic [4*DIGITS-1:0] b_bcd,
  output logic [4*DIGITS-1:0] diff_bcd,
  output logic                borrow,
  output logic                invalid
);

  logic       br;
  logic [4:0] d;

  // Ripple from the least significant digit; a negative digit result gets +10 and borrows
  always_comb begin
    br       = 1'b0;
    d        = '0;
    invalid  = 1'b0;
    diff_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, a_bcd[4*i +: 4]} - {1'b0, b_bcd[4*i +: 4]} - {4'b0000, br};
      if (d[4]) begin
        d  = d + 5'd10;
        br = 1'b1;
      end else begin
        br = 1'b0;
      end
      diff_bcd[4*i +: 4] = d[3:0];
      if ((a_bcd[4*i +: 4] > 4'd9) || (b_bcd[4*i +: 4] > 4'd9)) begin
        invalid = 1'b1;
      end
    end
    borrow = br;
  end

endmodule

// File: rtl/vend_purchase_ctrl.sv
// Purchase manager: captures a buy request, checks selection, credit format, stock and
// credit sufficiency, then either strobes the dispense output with BCD change or reports
// a coded error, each held for VEND_CYCLES cycles.
// Handshake: buy is a level; only its rising edge seen in IDLE starts a purchase. Edges
// arriving while busy are dropped. Results are registered strobes, not acknowledged.
module vend_purchase_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int DIGITS       = 2,
  parameter logic [NUM_PRODUCTS*4*DIGITS-1:0] PRICES = {8'h60, 8'h45, 8'h30, 8'h25},
  parameter int STOCK_INIT   = 3,
  parameter int VEND_CYCLES  = 2,
  localparam int SEL_W       = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    buy,
  input  logic [SEL_W-1:0]        product,
  input  logic [4*DIGITS-1:0]     credit_bcd,
  input  logic                    restock,
  output logic [NUM_PRODUCTS-1:0] vend,
  output logic [4*DIGITS-1:0]     change_bcd,
  output logic                    change_valid,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic                    busy,
  output logic [NUM_PRODUCTS-1:0] stock_empty
);

  localparam int CW     = 4 * DIGITS;
  localparam int HOLD_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

  state_e                    state_q, state_d;
  logic                      buy_q;
  logic [SEL_W-1:0]          prod_q;
  logic [CW-1:0]             cred_q;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [NUM_PRODUCTS-1:0]   vend_q, vend_d;
  logic [CW-1:0]             change_q, change_d;
  logic                      cv_q, cv_d;
  logic                      err_q, err_d;
  logic [1:0]                code_q, code_d;
  logic [STOCK_W-1:0]        stock_q [NUM_PRODUCTS];

  logic                      capture_en;
  logic                      dec_en;
  logic                      sel_ok;
  logic [CW-1:0]             price_sel;
  logic [STOCK_W-1:0]        stock_sel;
  logic [STOCK_W-1:0]        stock_avail;
  logic [CW-1:0]             sub_diff;
  logic                      sub_borrow;
  logic                      bcd_bad;

  // Look up price and stock of the captured product; out-of-range indices read as zero
  always_comb begin
    sel_ok    = ({1'b0, prod_q} < (SEL_W + 1)'(NUM_PRODUCTS));
    price_sel = '0;
    stock_sel = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (prod_q == SEL_W'(i)) begin
        price_sel = PRICES[i*CW +: CW];
        stock_sel = stock_q[i];
      end
    end
    // A restock landing on the evaluation edge counts as already applied
    stock_avail = restock ? STOCK_W'(STOCK_INIT) : stock_sel;
  end

  bcd_sub #(
    .DIGITS (DIGITS)
  ) u_bcd_sub (
    .a_bcd    (cred_q),
    .b_bcd    (price_sel),
    .diff_bcd (sub_diff),
    .borrow   (sub_borrow),
    .invalid  (bcd_bad)
  );

  // Next-state and next-output logic for the purchase sequencer
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    vend_d     = vend_q;
    change_d   = change_q;
    cv_d       = cv_q;
    err_d      = err_q;
    code_d     = code_q;
    capture_en = 1'b0;
    dec_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (buy && !buy_q) begin
          capture_en = 1'b1;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        hold_d   = HOLD_W'(VEND_CYCLES - 1);
        state_d  = ST_ERR;
        err_d    = 1'b1;
        change_d = '0;
        if (!sel_ok) begin
          code_d = ERR_BAD_SEL;
        end else if (bcd_bad) begin
          code_d = ERR_BAD_BCD;
        end else if (stock_avail == '0) begin
          code_d = ERR_SOLD_OUT;
        end else if (sub_borrow) begin
          code_d = ERR_INSUFF;
        end else begin
          state_d  = ST_VEND;
          err_d    = 1'b0;
          code_d   = 2'd0;
          vend_d   = NUM_PRODUCTS'(1) << prod_q;
          change_d = sub_diff;
          cv_d     = 1'b1;
          dec_en   = 1'b1;
        end
      end
      ST_VEND, ST_ERR: begin
        if (hold_q == '0) begin
          state_d  = ST_IDLE;
          vend_d   = '0;
          change_d = '0;
          cv_d     = 1'b0;
          err_d    = 1'b0;
          code_d   = 2'd0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request capture, buy history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      buy_q    <= 1'b0;
      prod_q   <= '0;
      cred_q   <= '0;
      hold_q   <= '0;
      vend_q   <= '0;
      change_q <= '0;
      cv_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      buy_q    <= buy;
      hold_q   <= hold_d;
      vend_q   <= vend_d;
      change_q <= change_d;
      cv_q     <= cv_d;
      err_q    <= err_d;
      code_q   <= code_d;
      if (capture_en) begin
        prod_q <= product;
        cred_q <= credit_bcd;
      end
    end
  end

  // Stock counters: restock overrides a same-cycle decrement; counters never go below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        if (restock) begin
          stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else if (dec_en && (prod_q == SEL_W'(i)) && (stock_q[i] != '0)) begin
          stock_q[i] <= stock_q[i] - STOCK_W'(1);
        end
      end
    end
  end

  // Empty flags decoded from the counter registers
  always_comb begin
    stock_empty = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) stock_empty[i] = (stock_q[i] == '0);
  end

  assign vend         = vend_q;
  assign change_bcd   = change_q;
  assign change_valid = cv_q;
  assign error        = err_q;
  assign err_code     = code_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_purchase_ctrl.sv
// Bench for vend_purchase_ctrl: directed purchases with literal expectations, a
// purchase-level reference model compared every cycle, and an expected-result queue.
module tb_vend_purchase_ctrl;

  localparam int NP = 4;
  localparam int VC = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       buy        = 1'b0;
  logic [1:0] product    = '0;
  logic [7:0] credit_bcd = '0;
  logic       restock    = 1'b0;
  logic [3:0] vend;
  logic [7:0] change_bcd;
  logic       change_valid;
  logic       error;
  logic [1:0] err_code;
  logic       busy;
  logic [3:0] stock_empty;

  vend_purchase_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buy          (buy),
    .product      (product),
    .credit_bcd   (credit_bcd),
    .restock      (restock),
    .vend         (vend),
    .change_bcd   (change_bcd),
    .change_valid (change_valid),
    .error        (error),
    .err_code     (err_code),
    .busy         (busy),
    .stock_empty  (stock_empty)
  );

  // Three-product build for the out-of-range selection case
  logic       buy3     = 1'b0;
  logic [1:0] product3 = '0;
  logic [7:0] credit3  = '0;
  logic       restock3 = 1'b0;
  logic [2:0] vend3;
  logic [7:0] change3;
  logic       cv3, err3, busy3;
  logic [1:0] code3;
  logic [2:0] empty3;

  vend_purchase_ctrl #(
    .NUM_PRODUCTS (3),
    .PRICES       (24'h453025)
  ) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .buy          (buy3),
    .product      (product3),
    .credit_bcd   (credit3),
    .restock      (restock3),
    .vend         (vend3),
    .change_bcd   (change3),
    .change_valid (cv3),
    .error        (err3),
    .err_code     (code3),
    .busy         (busy3),
    .stock_empty  (empty3)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         price_tab [NP] = '{25, 30, 45, 60};
  int         m_stock [NP];
  int         cyc, req_e, idle_from, m_prod;
  bit         active, m_prev_buy;
  logic [7:0] m_cred;
  logic [3:0] r_vend;
  logic [7:0] r_change;
  logic       r_err;
  logic [1:0] r_code;
  logic [3:0] e_vend, e_empty;
  logic [7:0] e_change;
  logic       e_cv, e_err, e_busy;
  logic [1:0] e_code;
  logic [14:0] exp_q[$];

  function automatic bit bad_bcd(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_stock[i] = 3;
    cyc = 0; req_e = 0; idle_from = 0; m_prod = 0;
    active = 0; m_prev_buy = 0; m_cred = '0;
    r_vend = '0; r_change = '0; r_err = 0; r_code = '0;
    e_vend = '0; e_change = '0; e_cv = 0; e_err = 0; e_code = '0; e_busy = 0;
    e_empty = '0;
    exp_q.delete();
  endtask

  // A purchase accepted at edge c is judged at edge c+1, shows its result after edges
  // c+1..c+VC, and the next request can be seen from edge c+VC+2 onwards.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit rs;
      bit did_vend;
      int avail;
      rs       = restock;
      did_vend = 0;
      cyc++;
      if (active && cyc > req_e + VC) active = 0;
      if (!active && cyc >= idle_from && buy && !m_prev_buy) begin
        active    = 1;
        req_e     = cyc;
        idle_from = cyc + VC + 2;
        m_prod    = int'(product);
        m_cred    = credit_bcd;
      end
      m_prev_buy = buy;
      if (active && cyc == req_e + 1) begin
        avail    = rs ? 3 : m_stock[m_prod];
        r_vend   = '0; r_change = '0; r_err = 1; r_code = '0;
        if (m_prod >= NP) r_code = 2'd3;
        else if (bad_bcd(m_cred)) r_code = 2'd2;
        else if (avail == 0) r_code = 2'd1;
        else if (bcd_val(m_cred) < price_tab[m_prod]) r_code = 2'd0;
        else begin
          r_err    = 0;
          r_vend   = 4'(1 << m_prod);
          r_change = to_bcd(bcd_val(m_cred) - price_tab[m_prod]);
          did_vend = 1;
        end
        exp_q.push_back({r_err, r_code, r_vend, r_change});
      end
      if (rs) begin
        for (int i = 0; i < NP; i++) m_stock[i] = 3;
      end else if (did_vend && m_stock[m_prod] > 0) begin
        m_stock[m_prod]--;
      end
      e_busy = active;
      if (active && cyc >= req_e + 1) begin
        e_vend = r_vend; e_change = r_change; e_cv = (r_vend != 0);
        e_err  = r_err;  e_code   = r_code;
      end else begin
        e_vend = '0; e_change = '0; e_cv = 0; e_err = 0; e_code = '0;
      end
      for (int i = 0; i < NP; i++) e_empty[i] = (m_stock[i] == 0);
    end
  end

  // ---------------- per-cycle compare and scoreboard ----------------
  bit prev_strobe = 0;
  always @(negedge clk) begin
    bit strobe;
    logic [14:0] exp_item;
    chk("m_vend",   vend,         e_vend);
    chk("m_change", change_bcd,   e_change);
    chk("m_cv",     change_valid, e_cv);
    chk("m_err",    error,        e_err);
    chk("m_code",   err_code,     e_code);
    chk("m_busy",   busy,         e_busy);
    chk("m_empty",  stock_empty,  e_empty);
    strobe = (vend != 0) || error;
    if (strobe && !prev_strobe) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_result", 1, 0);
      end else begin
        exp_item = exp_q.pop_front();
        chk("sb_result", {error, err_code, vend, change_bcd}, exp_item);
      end
    end
    prev_strobe = strobe;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_buy(input logic [1:0] p, input logic [7:0] c);
    @(negedge clk);
    product    = p;
    credit_bcd = c;
    buy        = 1'b1;
    @(negedge clk);
    buy        = 1'b0;
  endtask

  task automatic pulse_restock();
    @(negedge clk);
    restock = 1'b1;
    @(negedge clk);
    restock = 1'b0;
  endtask

  // One purchase with literal expectations across its whole result window
  task automatic buy_expect(input string tag, input logic [1:0] p, input logic [7:0] c,
                            input logic [3:0] ev, input logic [7:0] ec,
                            input logic ee, input logic [1:0] ecode);
    pulse_buy(p, c);
    chk({tag, "_busy"}, busy, 1);
    @(negedge clk);
    repeat (VC) begin
      chk({tag, "_vend"},   vend,         ev);
      chk({tag, "_change"}, change_bcd,   ec);
      chk({tag, "_cv"},     change_valid, (ev != 0));
      chk({tag, "_err"},    error,        ee);
      chk({tag, "_code"},   err_code,     ecode);
      @(negedge clk);
    end
    chk({tag, "_idle_vend"}, vend,  0);
    chk({tag, "_idle_err"},  error, 0);
    chk({tag, "_idle_busy"}, busy,  0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    tick(2);
    chk("rst_vend",  vend,         0);
    chk("rst_cv",    change_valid, 0);
    chk("rst_err",   error,        0);
    chk("rst_busy",  busy,         0);
    chk("rst_empty", stock_empty,  0);
    rst_n = 1'b1;
    tick(1);

    // insufficient credit, then good purchases and a price-equal purchase
    buy_expect("t1_insuff", 2'd0, 8'h00, 4'b0000, 8'h00, 1, 2'd0);
    chk("t1_stock", stock_empty, 0);
    buy_expect("t2_vend0", 2'd0, 8'h75, 4'b0001, 8'h50, 0, 2'd0);
    buy_expect("t3_exact", 2'd2, 8'h45, 4'b0100, 8'h00, 0, 2'd0);
    buy_expect("t3_insuff", 2'd3, 8'h45, 4'b0000, 8'h00, 1, 2'd0);
    buy_expect("t4_badbcd", 2'd1, 8'h7A, 4'b0000, 8'h00, 1, 2'd2);

    // buy held high for 10 cycles: a single evaluation
    @(negedge clk);
    product = 2'd1; credit_bcd = 8'h50; buy = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (vend == 4'b0010) cnt++;
    end
    buy = 1'b0;
    tick(3);
    chk("t4_held_one_eval", cnt, VC);

    // drain product 0 from a fresh restock
    pulse_restock();
    buy_expect("t5_b1", 2'd0, 8'h99, 4'b0001, 8'h74, 0, 2'd0);
    buy_expect("t5_b2", 2'd0, 8'h99, 4'b0001, 8'h74, 0, 2'd0);
    chk("t5_not_empty", stock_empty, 4'b0000);
    buy_expect("t5_b3", 2'd0, 8'h99, 4'b0001, 8'h74, 0, 2'd0);
    chk("t5_empty", stock_empty, 4'b0001);
    buy_expect("t5_soldout", 2'd0, 8'h99, 4'b0000, 8'h00, 1, 2'd1);

    // restock on the evaluation edge: sold-out item vends and the counter ends at full
    @(negedge clk);
    product = 2'd0; credit_bcd = 8'h99; buy = 1'b1;
    @(negedge clk);
    buy = 1'b0; restock = 1'b1;
    @(negedge clk);
    restock = 1'b0;
    chk("t5_rs_vend",   vend,       4'b0001);
    chk("t5_rs_change", change_bcd, 8'h74);
    tick(2);
    chk("t5_rs_empty", stock_empty, 0);
    buy_expect("t5_c1", 2'd0, 8'h99, 4'b0001, 8'h74, 0, 2'd0);
    buy_expect("t5_c2", 2'd0, 8'h99, 4'b0001, 8'h74, 0, 2'd0);
    chk("t5_rs_full", stock_empty, 4'b0000);
    buy_expect("t5_c3", 2'd0, 8'h99, 4'b0001, 8'h74, 0, 2'd0);
    chk("t5_rs_drained", stock_empty, 4'b0001);
    pulse_restock();
    chk("t5_restock", stock_empty, 0);
    buy_expect("t5_b5", 2'd0, 8'h25, 4'b0001, 8'h00, 0, 2'd0);

    // a second buy edge during VEND is dropped
    @(negedge clk);
    product = 2'd2; credit_bcd = 8'h99; buy = 1'b1;
    cnt = 0;
    @(negedge clk);
    buy = 1'b0;
    @(negedge clk);
    if (vend != 0) cnt++;
    buy = 1'b1; product = 2'd1;
    @(negedge clk);
    if (vend != 0) cnt++;
    buy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (vend != 0) cnt++;
    end
    chk("t6_busy_drop", cnt, VC);

    // asynchronous reset in the middle of a vend
    pulse_buy(2'd0, 8'h99);
    @(negedge clk);
    chk("t6_pre_rst_vend", vend, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vend", vend,         0);
    chk("t6_rst_cv",   change_valid, 0);
    chk("t6_rst_busy", busy,         0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_rst_empty", stock_empty, 0);
    buy_expect("t6_r1", 2'd0, 8'h99, 4'b0001, 8'h74, 0, 2'd0);
    buy_expect("t6_r2", 2'd0, 8'h99, 4'b0001, 8'h74, 0, 2'd0);
    chk("t6_rst_full", stock_empty, 4'b0000);
    buy_expect("t6_r3", 2'd0, 8'h99, 4'b0001, 8'h74, 0, 2'd0);
    chk("t6_rst_drained", stock_empty, 4'b0001);

    // three-product build: index 3 is an invalid selection, index 2 still sells
    @(negedge clk);
    product3 = 2'd3; credit3 = 8'h99; buy3 = 1'b1;
    @(negedge clk);
    buy3 = 1'b0;
    @(negedge clk);
    chk("t7_badsel_err",  err3,  1);
    chk("t7_badsel_code", code3, 2'd3);
    chk("t7_badsel_vend", vend3, 0);
    tick(3);
    @(negedge clk);
    product3 = 2'd2; credit3 = 8'h50; buy3 = 1'b1;
    @(negedge clk);
    buy3 = 1'b0;
    @(negedge clk);
    chk("t7_vend2",   vend3,   3'b100);
    chk("t7_change2", change3, 8'h05);
    tick(4);

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
